// File: rtl/snn_mem_reader.sv
// Read-side burst sequencer: streams words 0..len-1 from a 1-cycle-latency RAM
// onto a valid/ready interface through a 2-entry elastic buffer.
module snn_mem_reader #(
    parameter int DEPTH  = 8192,
    parameter int DATA_W = 16,
    localparam int AW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     len,
    input  logic              abort,
    output logic              mem_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int NBUF = 2;
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     len_reg, issued_reg, rd_cnt_reg, addr_reg;
    logic [1:0]        occ_reg;
    logic              infl_reg, done_reg;
    logic              issue, pop, flush, buf_push, buf_pop;
    logic [1:0]        wr_pos;
    logic [DATA_W-1:0] buf_q [NBUF];

    assign pop       = out_valid && out_ready;
    assign flush     = abort && (state_reg != IDLE);
    assign buf_push  = infl_reg && !flush;
    assign buf_pop   = pop && !flush;
    // Slot the returning word lands in, after any same-cycle shift from a pop.
    assign wr_pos    = occ_reg - {1'b0, buf_pop};

    assign out_valid = (occ_reg != 2'd0);
    assign out_data  = buf_q[0];
    assign out_last  = out_valid && (rd_cnt_reg == len_reg - ONE);
    assign done      = done_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start && (len != '0)) state_next = READ;
            end
            READ: begin
                if (abort)                                      state_next = IDLE;
                else if (issue && (issued_reg + ONE == len_reg)) state_next = DRAIN;
            end
            DRAIN: begin
                if (abort)                 state_next = IDLE;
                else if (pop && out_last)  state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Issue only while the buffer plus the in-flight read leaves room after this cycle's pop.
    always_comb begin
        issue = 1'b0;
        if ((state_reg == READ) && !abort && (issued_reg < len_reg) &&
            (({1'b0, occ_reg} + {2'b00, infl_reg}) < (3'd2 + {2'b00, pop})))
            issue = 1'b1;
        mem_en   = issue;
        mem_addr = issue ? issued_reg : addr_reg;
        busy     = (state_reg != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_reg    <= '0;
            issued_reg <= '0;
            rd_cnt_reg <= '0;
            addr_reg   <= '0;
            occ_reg    <= 2'd0;
            infl_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == IDLE) begin
                infl_reg <= 1'b0;
                occ_reg  <= 2'd0;
                if (start) begin
                    if (len == '0) begin
                        done_reg <= 1'b1;
                    end else begin
                        len_reg    <= len;
                        issued_reg <= '0;
                        rd_cnt_reg <= '0;
                    end
                end
            end else if (flush) begin
                occ_reg  <= 2'd0;
                infl_reg <= 1'b0;
            end else begin
                infl_reg <= issue;
                if (issue) begin
                    issued_reg <= issued_reg + ONE;
                    addr_reg   <= issued_reg;
                end
                if (pop) rd_cnt_reg <= rd_cnt_reg + ONE;
                occ_reg <= occ_reg + {1'b0, buf_push} - {1'b0, buf_pop};
                if ((state_reg == DRAIN) && pop && out_last) done_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBUF; gi++) begin : g_buf
            logic [DATA_W-1:0] entry_reg;
            logic [DATA_W-1:0] shift_in;
            if (gi < NBUF - 1) begin : g_shift
                assign shift_in = buf_q[gi+1];
            end else begin : g_tail
                assign shift_in = '0;
            end
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    entry_reg <= '0;
                else if (buf_push && (wr_pos == 2'(gi)))
                    entry_reg <= mem_rdata;
                else if (buf_pop && (occ_reg > 2'(gi + 1)))
                    entry_reg <= shift_in;
            end
            assign buf_q[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: tb/tb_snn_mem_reader.sv
// Bench for snn_mem_reader: RAM model plus a queue-based expectation of the
// streamed words, timing and handshake properties per burst.
module tb_snn_mem_reader;

    localparam int DEPTH = 8192;
    localparam int AW    = 14;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, out_ready;
    logic [AW-1:0] len;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          out_valid, out_last, busy, done;
    logic [DW-1:0] out_data;

    logic [DW-1:0] mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    int r_first_en, r_last_en, r_en_cnt, r_last_addr, r_first_valid, r_last_hs, r_n_hs;
    int r_last_flag, r_done_cnt, r_done_c, r_busy_first, r_busy_last;
    int r_occ_bad, r_timeout, r_ab_valid, r_ab_busy, r_left;

    snn_mem_reader #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en) mem_rdata <= mem[int'(mem_addr)];

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one burst starting in cycle 0 (caller is just after a rising edge).
    // rmode: 0 ready=1, 1 pattern 1,0,0,1, 2 ready=0, 3 random.
    task automatic burst(input int n, input int rmode, input int abort_at, input int limit);
        logic [DW-1:0] expq[$];
        int c;
        bit fin;
        for (int i = 0; i < n; i++) expq.push_back(mem[i]);
        r_first_en = -1; r_last_en = -1; r_en_cnt = 0; r_last_addr = -1;
        r_first_valid = -1; r_last_hs = -1; r_n_hs = 0; r_last_flag = -1;
        r_done_cnt = 0; r_done_c = -1; r_busy_first = -1; r_busy_last = -1;
        r_occ_bad = 0; r_timeout = 0; r_ab_valid = -1; r_ab_busy = -1;
        c = 0; fin = 0;
        while (!fin) begin
            start = (c == 0);
            len   = (c == 0) ? AW'(n) : AW'($urandom);
            abort = (c == abort_at);
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((c % 4) == 0) || ((c % 4) == 3);
                2:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (mem_en) begin
                if (r_first_en < 0) r_first_en = c;
                r_last_en = c;
                r_last_addr = int'(mem_addr);
                check("mem_addr", 64'(mem_addr), 64'(r_en_cnt));
                r_en_cnt++;
            end
            if (out_valid) begin
                if (r_first_valid < 0) r_first_valid = c;
                if (expq.size() == 0) check("extra_valid", 64'(out_valid), 64'(0));
                else begin
                    check("out_data", 64'(out_data), 64'(expq[0]));
                    check("out_last", 64'(out_last), 64'(expq.size() == 1));
                end
            end
            if (out_valid && out_ready) begin
                if (expq.size() > 0) void'(expq.pop_front());
                r_n_hs++;
                r_last_hs = c;
                if (out_last) r_last_flag = c;
            end
            if (done) begin r_done_cnt++; r_done_c = c; end
            if (busy) begin
                if (r_busy_first < 0) r_busy_first = c;
                r_busy_last = c;
            end
            if (r_en_cnt - r_n_hs > 2) r_occ_bad = 1;
            if (c == abort_at + 1) begin r_ab_valid = int'(out_valid); r_ab_busy = int'(busy); end
            @(posedge clk); #1;
            c++;
            if (abort_at >= 0) fin = (c > abort_at + 4);
            else if (r_done_c >= 0 && c > r_done_c + 2) fin = 1;
            if (!fin && c > limit) begin fin = 1; r_timeout = 1; end
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        r_left = expq.size();
        check("timeout", 64'(r_timeout), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(16'h0100 + i);
        rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_valid", 64'(out_valid), 64'(0));
        check("reset_mem_en", 64'(mem_en), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_data", 64'(out_data), 64'(0));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // len=4, ready high: exact latency and timing
        burst(4, 0, -1, 40);
        check("l4_first_en", 64'(r_first_en), 64'(1));
        check("l4_last_en", 64'(r_last_en), 64'(4));
        check("l4_first_valid", 64'(r_first_valid), 64'(3));
        check("l4_last_hs", 64'(r_last_hs), 64'(6));
        check("l4_last_flag", 64'(r_last_flag), 64'(6));
        check("l4_done_c", 64'(r_done_c), 64'(7));
        check("l4_done_cnt", 64'(r_done_cnt), 64'(1));
        check("l4_busy_first", 64'(r_busy_first), 64'(1));
        check("l4_busy_last", 64'(r_busy_last), 64'(6));
        $display("burst len=4 ready=1 hs=%0d done_cycle=%0d", r_n_hs, r_done_c);

        // len=8 with toggling ready
        burst(8, 1, -1, 100);
        check("l8_n_hs", 64'(r_n_hs), 64'(8));
        check("l8_left", 64'(r_left), 64'(0));
        check("l8_occ", 64'(r_occ_bad), 64'(0));
        check("l8_done_cnt", 64'(r_done_cnt), 64'(1));
        check("l8_done_after_last", 64'(r_done_c), 64'(r_last_flag + 1));
        $display("burst len=8 ready=1001 hs=%0d done_cycle=%0d", r_n_hs, r_done_c);

        // len=0
        burst(0, 0, -1, 20);
        check("l0_en", 64'(r_en_cnt), 64'(0));
        check("l0_valid", 64'(r_first_valid), 64'(-1));
        check("l0_done_c", 64'(r_done_c), 64'(1));
        check("l0_done_cnt", 64'(r_done_cnt), 64'(1));
        check("l0_busy", 64'(r_busy_first), 64'(-1));
        $display("burst len=0 done_cycle=%0d", r_done_c);

        // len=DEPTH
        burst(DEPTH, 0, -1, DEPTH + 40);
        check("full_n_hs", 64'(r_n_hs), 64'(DEPTH));
        check("full_last_addr", 64'(r_last_addr), 64'(DEPTH - 1));
        check("full_last_flag", 64'(r_last_flag), 64'(DEPTH + 2));
        check("full_done_c", 64'(r_done_c), 64'(DEPTH + 3));
        $display("burst len=%0d ready=1 hs=%0d last_addr=%0d", DEPTH, r_n_hs, r_last_addr);

        // abort in cycle 6 with ready low, then a short burst
        burst(16, 2, 6, 40);
        check("ab_valid", 64'(r_ab_valid), 64'(0));
        check("ab_busy", 64'(r_ab_busy), 64'(0));
        check("ab_done", 64'(r_done_cnt), 64'(0));
        check("ab_occ", 64'(r_occ_bad), 64'(0));
        $display("burst len=16 abort@6 issued=%0d", r_en_cnt);
        burst(2, 0, -1, 30);
        check("post_ab_en", 64'(r_en_cnt), 64'(2));
        check("post_ab_hs", 64'(r_n_hs), 64'(2));
        check("post_ab_done", 64'(r_done_cnt), 64'(1));
        $display("burst len=2 after abort hs=%0d", r_n_hs);

        // asynchronous reset mid-burst
        start = 1'b1; len = AW'(20); out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_busy", 64'(busy), 64'(1));
        #2 rst = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_last", 64'(out_last), 64'(0));
        check("rst_mem_en", 64'(mem_en), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        $display("async reset mid-burst busy=%0d valid=%0d", busy, out_valid);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        burst(3, 0, -1, 30);
        check("post_rst_hs", 64'(r_n_hs), 64'(3));
        check("post_rst_done", 64'(r_done_c), 64'(6));
        $display("burst len=3 after reset hs=%0d", r_n_hs);

        // randomized bursts with random contents and backpressure
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 40);
            for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
            burst(n, 3, -1, 20 * n + 40);
            check("rnd_n_hs", 64'(r_n_hs), 64'(n));
            check("rnd_left", 64'(r_left), 64'(0));
            check("rnd_occ", 64'(r_occ_bad), 64'(0));
            check("rnd_done_cnt", 64'(r_done_cnt), 64'(1));
            $display("burst len=%0d ready=random hs=%0d done_cycle=%0d", n, r_n_hs, r_done_c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
